// File: rtl/bus_register_tri.sv
// bus_register_tri
// Clocked bus-slave register file for a 68000-style strobe bus (strobes already
// synchronous to clk). One chip select, 2**ADDR_BITS words of WIDTH bits,
// programmable wait states before a tristate active-low acknowledge, and a
// tristate read-data bus whose enable is mirrored on data_oe.
`timescale 1ns/1ps

module bus_register_tri #(
    parameter int          WIDTH       = 8,
    parameter int          ADDR_BITS   = 2,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] RESET_VALUE = 32'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs_n,
    input  logic                 ds_n,
    input  logic                 rw,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [WIDTH-1:0]     data_in,
    output tri   [WIDTH-1:0]     data_out,
    output logic                 data_oe,
    output tri                   dtack_n
);

    localparam int               DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0]       LP_WAIT = 4'(WAIT_STATES);
    localparam logic [WIDTH-1:0] LP_RST  = RESET_VALUE[WIDTH-1:0];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Bus-cycle state
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_armed;     // strobes have been seen high since the last cycle start / reset
    logic [ADDR_BITS-1:0]  r_addr;
    logic                  r_rw;

    // Storage
    logic [WIDTH-1:0]      r_regs [DEPTH];

    // Registered output controls
    logic                  r_oe;
    logic                  r_dtack_en;
    logic                  r_dtack_hi;

    // Next-state decode
    state_t                w_state_nxt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_armed_nxt;
    logic [ADDR_BITS-1:0]  w_addr_nxt;
    logic                  w_rw_nxt;
    logic                  w_wr_en;
    logic [ADDR_BITS-1:0]  w_wr_addr;
    logic                  w_strobe_lo;
    logic [WIDTH-1:0]      w_rdata;

    assign w_strobe_lo = (cs_n == 1'b0) && (ds_n == 1'b0);

    // Next-state, write-commit and latch decode for the bus-cycle FSM
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_armed_nxt = r_armed;
        w_addr_nxt  = r_addr;
        w_rw_nxt    = r_rw;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_addr;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe_lo && r_armed) begin
                    // Cycle start: address and direction are captured here and
                    // ignored for the rest of the cycle.
                    w_armed_nxt = 1'b0;
                    w_addr_nxt  = addr;
                    w_rw_nxt    = rw;
                    w_wr_addr   = addr;
                    if (LP_WAIT == 4'd0) begin
                        // Zero-wait: ACK is entered on the start edge, so the
                        // write commits with the live address and data.
                        w_state_nxt = ST_ACK;
                        w_cnt_nxt   = 4'd0;
                        w_wr_en     = ~rw;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = LP_WAIT;
                    end
                end else if (!w_strobe_lo) begin
                    // Strobes seen high: a following low strobe is a new cycle.
                    w_armed_nxt = 1'b1;
                end else begin
                    // Strobes still low from before reset/previous cycle: wait.
                    w_armed_nxt = r_armed;
                end
            end
            ST_WAIT: begin
                if (!w_strobe_lo) begin
                    // Abort: no commit, registers untouched.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    w_armed_nxt = 1'b1;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_ACK;
                    w_cnt_nxt   = 4'd0;
                    w_wr_en     = ~r_rw;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                if (!w_strobe_lo) begin
                    w_state_nxt = ST_IDLE;
                    w_armed_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_ACK;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
                w_armed_nxt = 1'b0;
            end
        endcase
    end

    // FSM state, wait counter and latched address/direction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_armed <= 1'b0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_armed <= w_armed_nxt;
            r_addr  <= w_addr_nxt;
            r_rw    <= w_rw_nxt;
        end
    end

    // Register file: reset to RESET_VALUE, one write on ACK entry of a write cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= LP_RST;
            end
        end else if (w_wr_en) begin
            r_regs[w_wr_addr] <= data_in;
        end
    end

    // Output drive controls registered from the next state so enables never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oe       <= 1'b0;
            r_dtack_en <= 1'b0;
            r_dtack_hi <= 1'b0;
        end else begin
            r_oe       <= (w_state_nxt != ST_IDLE) && w_rw_nxt;
            r_dtack_en <= (w_state_nxt != ST_IDLE);
            r_dtack_hi <= (w_state_nxt == ST_WAIT);
        end
    end

    // Read data comes from storage only; reads and writes never overlap in time.
    assign w_rdata  = r_regs[r_addr];
    assign data_oe  = r_oe;
    assign data_out = r_oe ? w_rdata : {WIDTH{1'bz}};
    assign dtack_n  = r_dtack_en ? r_dtack_hi : 1'bz;

endmodule
